mmio_arbiter: RTL

Two-master arbiter for the single MMIO bus that feeds `mmio_top`. It sits between `io_mmio_bridge` (master 0, MicroBlaze MCS) and a second on-chip master (master 1, e.g. an audio DMA/sequencer) on one side, and the MMIO slot decoder on the other. Each master runs a req/ack handshake. The arbiter grants the bus round-robin and issues one single-cycle MMIO strobe per transaction. For reads, it captures the read data after a fixed slot latency and returns it to the granted master.

---
 rtl/mmio_arb_pkg.sv | 16 +
 rtl/rr_arbiter_2.sv | 40 ++++
 rtl/mmio_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mmio_arb_pkg.sv
// Shared MMIO bus constants and arbiter FSM state type.
// Imported by the arbiter, the bridge side and the slot decoder.
package mmio_arb_pkg;

    localparam int MMIO_ADDR_W = 21;
    localparam int MMIO_DATA_W = 32;
    localparam int LAT_CNT_W   = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } mmio_arb_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: combinational one-hot grant,
// registered last-grant flag updated when a transaction completes.
module rr_arbiter_2 (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_upd_id,
    output logic [1:0] o_grant
);

    logic r_last;
    logic w_both;
    logic w_only0;
    logic w_only1;

    assign w_both  = i_req[0] & i_req[1];
    assign w_only0 = i_req[0] & ~i_req[1];
    assign w_only1 = i_req[1] & ~i_req[0];

    always_comb begin
        o_grant = 2'b00;
        unique case (1'b1)
            w_both:  o_grant = r_last ? 2'b01 : 2'b10;
            w_only0: o_grant = 2'b01;
            w_only1: o_grant = 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    // Reset to master 1 so master 0 wins the first tie.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_last <= 1'b1;
        end else if (i_update) begin
            r_last <= i_upd_id;
        end
    end

endmodule

// File: rtl/mmio_arbiter.sv
// Two-master MMIO bus arbiter: round-robin grant, one strobe per
// transaction, read data captured after a fixed slot latency.
module mmio_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int ADDR_W     = MMIO_ADDR_W,
    parameter int DATA_W     = MMIO_DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_m0_req,
    input  logic              i_m0_write,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_ack,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic              i_m1_write,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_ack,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_mmio_cs,
    output logic              o_mmio_write,
    output logic              o_mmio_read,
    output logic [ADDR_W-1:0] o_mmio_addr,
    output logic [DATA_W-1:0] o_mmio_write_data,
    input  logic [DATA_W-1:0] i_mmio_read_data
);

    mmio_arb_state_t        r_state;
    logic                   r_sel;
    logic                   r_write;
    logic [LAT_CNT_W-1:0]   r_cnt;
    logic                   r_mmio_cs;
    logic                   r_mmio_write;
    logic                   r_mmio_read;
    logic [ADDR_W-1:0]      r_mmio_addr;
    logic [DATA_W-1:0]      r_mmio_wdata;
    logic                   r_m0_ack;
    logic                   r_m1_ack;
    logic [DATA_W-1:0]      r_m0_rdata;
    logic [DATA_W-1:0]      r_m1_rdata;

    logic [1:0]             w_grant;
    logic                   w_pick1;
    logic                   w_sel_write;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_wdata;

    rr_arbiter_2 u_rr (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_req     ({i_m1_req, i_m0_req}),
        .i_update  (r_state == ACK),
        .i_upd_id  (r_sel),
        .o_grant   (w_grant)
    );

    assign w_pick1     = w_grant[1];
    assign w_sel_write = w_pick1 ? i_m1_write : i_m0_write;
    assign w_sel_addr  = w_pick1 ? i_m1_addr  : i_m0_addr;
    assign w_sel_wdata = w_pick1 ? i_m1_wdata : i_m0_wdata;

    // The MMIO output registers double as the latched addr/wdata;
    // they are loaded on entry to ISSUE and cleared on exit.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_sel        <= 1'b0;
            r_write      <= 1'b0;
            r_cnt        <= '0;
            r_mmio_cs    <= 1'b0;
            r_mmio_write <= 1'b0;
            r_mmio_read  <= 1'b0;
            r_mmio_addr  <= '0;
            r_mmio_wdata <= '0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_sel        <= w_pick1;
                        r_write      <= w_sel_write;
                        r_mmio_cs    <= 1'b1;
                        r_mmio_write <= w_sel_write;
                        r_mmio_read  <= ~w_sel_write;
                        r_mmio_addr  <= w_sel_addr;
                        r_mmio_wdata <= w_sel_wdata;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_mmio_cs    <= 1'b0;
                    r_mmio_write <= 1'b0;
                    r_mmio_read  <= 1'b0;
                    r_mmio_addr  <= '0;
                    r_mmio_wdata <= '0;
                    if (r_write) begin
                        r_m0_ack <= ~r_sel;
                        r_m1_ack <= r_sel;
                        r_state  <= ACK;
                    end else begin
                        r_cnt   <= LAT_CNT_W'(RD_LATENCY - 1);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        if (r_sel) begin
                            r_m1_rdata <= i_mmio_read_data;
                        end else begin
                            r_m0_rdata <= i_mmio_read_data;
                        end
                        r_m0_ack <= ~r_sel;
                        r_m1_ack <= r_sel;
                        r_state  <= ACK;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_mmio_cs         = r_mmio_cs;
    assign o_mmio_write      = r_mmio_write;
    assign o_mmio_read       = r_mmio_read;
    assign o_mmio_addr       = r_mmio_addr;
    assign o_mmio_write_data = r_mmio_wdata;
    assign o_m0_ack          = r_m0_ack;
    assign o_m1_ack          = r_m1_ack;
    assign o_m0_rdata        = r_m0_rdata;
    assign o_m1_rdata        = r_m1_rdata;

endmodule
